// File: rtl/filt_feed_ctrl_if.sv
// filt_feed_ctrl_if: upstream sample handshake into the filter feeder.
// Signals: s_valid/s_data (producer -> feeder), s_ready (feeder -> producer).
interface filt_feed_ctrl_if;
    logic               s_valid;
    logic signed [17:0] s_data;
    logic               s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/filt_feed_ctrl.sv
// filt_feed_ctrl: input FIFO plus IDLE/RUN/FLUSH sequencer feeding a
// fixed-latency filter; a tag pipeline marks which filter outputs are real.
// Ports: clk; reset (sync, active-high); s (slave: s_valid, s_data, s_ready);
// flush_req; x_in (to filter); y (from filter); y_out/y_valid (registered
// filter output and its qualifier); busy; underrun pulse; underrun_cnt.
module filt_feed_ctrl #(
    parameter int DEPTH     = 8,
    parameter int PRIME     = 4,
    parameter int LATENCY   = 4,
    parameter int FLUSH_LEN = 21
) (
    input  logic               clk,
    input  logic               reset,
    filt_feed_ctrl_if.slave    s,
    input  logic               flush_req,
    output logic signed [17:0] x_in,
    input  logic signed [17:0] y,
    output logic signed [17:0] y_out,
    output logic               y_valid,
    output logic               busy,
    output logic               underrun,
    output logic [15:0]        underrun_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FLUSH_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t             state_q;
    logic signed [17:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic [FW-1:0]      flush_cnt_q;
    logic signed [17:0] x_q;
    logic               tag_q;
    logic [LATENCY-1:0] tag_sr_q;
    logic signed [17:0] y_out_q;
    logic               y_valid_q;
    logic               underrun_q;
    logic [15:0]        ucnt_q;

    logic ready_w;
    logic push_w;
    logic pop_w;
    logic flush_go_w;

    // Ready depends on registered state only, so a full FIFO never takes
    // a word even on a cycle where it also pops.
    always_comb begin
        ready_w    = (count_q < CW'(DEPTH)) && (state_q != FLUSH);
        push_w     = s.s_valid && ready_w;
        flush_go_w = flush_req && (state_q != FLUSH);
        pop_w      = (state_q == RUN) && (count_q != '0) && !flush_go_w;
        if (flush_go_w) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(push_w) - CW'(pop_w);
        end
    end

    always_ff @(posedge clk) begin
        if (push_w) begin
            mem[wr_ptr_q] <= s.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            flush_cnt_q <= '0;
            x_q         <= '0;
            tag_q       <= 1'b0;
            tag_sr_q    <= '0;
            y_out_q     <= '0;
            y_valid_q   <= 1'b0;
            underrun_q  <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            count_q    <= count_d;
            underrun_q <= 1'b0;
            y_out_q    <= y;
            // Tag rides alongside x_in through the filter latency.
            tag_sr_q   <= (tag_sr_q << 1) | LATENCY'(tag_q);
            y_valid_q  <= tag_sr_q[LATENCY-1];
            if (push_w) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_w) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end

            if (flush_go_w) begin
                // Flush wins over every other transition and drops the queue.
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                x_q         <= '0;
                tag_q       <= 1'b0;
                flush_cnt_q <= FW'(FLUSH_LEN - 1);
                state_q     <= FLUSH;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        x_q   <= '0;
                        tag_q <= 1'b0;
                        if (count_q >= CW'(PRIME)) begin
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        if (pop_w) begin
                            x_q   <= mem[rd_ptr_q];
                            tag_q <= 1'b1;
                        end else begin
                            x_q        <= '0;
                            tag_q      <= 1'b0;
                            underrun_q <= 1'b1;
                            if (ucnt_q != 16'hFFFF) begin
                                ucnt_q <= ucnt_q + 16'd1;
                            end
                            state_q <= IDLE;
                        end
                    end
                    FLUSH: begin
                        x_q   <= '0;
                        tag_q <= 1'b0;
                        // Counter was loaded with FLUSH_LEN-1 on entry, so
                        // FLUSH lasts FLUSH_LEN cycles in total.
                        if (flush_cnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            flush_cnt_q <= flush_cnt_q - FW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign s.s_ready    = ready_w;
    assign x_in         = x_q;
    assign y_out        = y_out_q;
    assign y_valid      = y_valid_q;
    assign busy         = (state_q != IDLE);
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_filt_feed_ctrl.sv
// tb_filt_feed_ctrl: directed bench with a queue-based reference model
// and a delay-line stand-in for the filter.
module tb_filt_feed_ctrl;

    localparam int DEPTH = 8;
    localparam int PRIME = 4;
    localparam int LAT   = 4;
    localparam int FL    = 21;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               fr  = 1'b0;
    logic signed [17:0] y   = '0;
    logic signed [17:0] x_in;
    logic signed [17:0] y_out;
    logic               y_valid;
    logic               busy;
    logic               underrun;
    logic [15:0]        ucnt;

    logic signed [17:0] bp_x;
    logic signed [17:0] bp_yo;
    logic               bp_yv;
    logic               bp_busy;
    logic               bp_und;
    logic [15:0]        bp_ucnt;

    filt_feed_ctrl_if bus ();
    filt_feed_ctrl_if bp ();

    filt_feed_ctrl #(
        .DEPTH(DEPTH), .PRIME(PRIME), .LATENCY(LAT), .FLUSH_LEN(FL)
    ) u_dut (
        .clk(clk), .reset(rst), .s(bus), .flush_req(fr),
        .x_in(x_in), .y(y), .y_out(y_out), .y_valid(y_valid),
        .busy(busy), .underrun(underrun), .underrun_cnt(ucnt)
    );

    filt_feed_ctrl #(
        .DEPTH(8), .PRIME(9), .LATENCY(LAT), .FLUSH_LEN(FL)
    ) u_bp (
        .clk(clk), .reset(rst), .s(bp), .flush_req(1'b0),
        .x_in(bp_x), .y(18'sd0), .y_out(bp_yo), .y_valid(bp_yv),
        .busy(bp_busy), .underrun(bp_und), .underrun_cnt(bp_ucnt)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Filter stand-in: y in cycle c equals x_in of cycle c-LAT.
    logic signed [17:0] fh[$];
    always @(posedge clk) begin
        #1;
        fh.push_front($isunknown(x_in) ? 18'sd0 : x_in);
        y = fh[LAT];
        if (fh.size() > LAT + 1) void'(fh.pop_back());
    end

    // Reference model: a plain queue plus a mode and a flush countdown.
    typedef enum int {M_IDLE, M_RUN, M_FLUSH} mmode_t;
    mmode_t             mode = M_IDLE;
    logic signed [17:0] q[$];
    int                 frem;
    logic signed [17:0] hx[$];
    bit                 ht[$];
    logic signed [17:0] e_x, e_yout, nx;
    bit                 e_yv, nt, e_und, acc, started = 0;
    int                 e_ucnt = 0;

    initial begin
        for (int i = 0; i <= LAT; i++) begin
            hx.push_back('0);
            ht.push_back(1'b0);
        end
    end

    always @(posedge clk) begin
        nx = '0;
        nt = 1'b0;
        e_und = 1'b0;
        if (rst) begin
            mode = M_IDLE;
            q.delete();
            e_ucnt = 0;
            foreach (ht[i]) ht[i] = 1'b0;
            hx.push_front('0);
            ht.push_front(1'b0);
            e_yout = '0;
            e_yv = 1'b0;
            started = 1;
        end else begin
            acc = bus.s_valid && (q.size() < DEPTH) && (mode != M_FLUSH);
            if (fr && mode != M_FLUSH) begin
                q.delete();
                acc = 0;
                mode = M_FLUSH;
                frem = FL;
            end else begin
                case (mode)
                    M_IDLE: if (q.size() >= PRIME) mode = M_RUN;
                    M_RUN: begin
                        if (q.size() > 0) begin
                            nx = q.pop_front();
                            nt = 1'b1;
                        end else begin
                            e_und = 1'b1;
                            if (e_ucnt < 65535) e_ucnt++;
                            mode = M_IDLE;
                        end
                    end
                    default: begin
                        frem--;
                        if (frem == 0) mode = M_IDLE;
                    end
                endcase
            end
            if (acc) q.push_back(bus.s_data);
            hx.push_front(nx);
            ht.push_front(nt);
            e_yout = hx[LAT+1];
            e_yv = ht[LAT+1];
        end
        e_x = nx;
        if (hx.size() > LAT + 2) begin
            void'(hx.pop_back());
            void'(ht.pop_back());
        end
    end

    logic signed [17:0] ylog[$];
    int                 n_und = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("x_in", x_in, e_x);
            chk("y_out", y_out, e_yout);
            chk("y_valid", y_valid, e_yv);
            chk("s_ready", bus.s_ready, (q.size() < DEPTH) && (mode != M_FLUSH));
            chk("busy", busy, mode != M_IDLE);
            chk("underrun", underrun, e_und);
            chk("underrun_cnt", ucnt, e_ucnt[15:0]);
            if (y_valid === 1'b1) ylog.push_back(y_out);
            if (underrun === 1'b1) n_und++;
        end
    end

    function automatic logic signed [17:0] getlog(int i);
        if (i < ylog.size()) return ylog[i];
        return 'x;
    endfunction

    task automatic step(bit v, logic signed [17:0] d, bit f);
        bus.s_valid = v;
        bus.s_data = d;
        fr = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, '0, 1'b0);
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
        ylog.delete();
        n_und = 0;
    endtask

    logic signed [17:0] pat[2];
    int lows;
    int bp_acc;

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bp.s_valid = 1'b0;
        bp.s_data = '0;
        pat[0] = 18'sh1FFFF;
        pat[1] = 18'sh20000;

        // Reset state, priming and in-order streaming.
        do_reset(2);
        chk("rst_ready", bus.s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ucnt", ucnt, 0);
        chk("rst_x", x_in, 0);
        for (int k = 1; k <= 4; k++) step(1'b1, 18'(k), 1'b0);
        chk("prime_idle", busy, 0);
        step(1'b1, 18'sd5, 1'b0);
        chk("prime_run", busy, 1);
        for (int k = 6; k <= 10; k++) step(1'b1, 18'(k), 1'b0);
        idle(20);
        chk("stream_n", ylog.size(), 10);
        for (int i = 0; i < 10; i++) chk("stream_val", getlog(i), 32'(i + 1));

        // Underrun after four samples.
        do_reset(1);
        for (int k = 0; k < 4; k++) step(1'b1, 18'(200 + k), 1'b0);
        idle(15);
        chk("und_n", ylog.size(), 4);
        for (int i = 0; i < 4; i++) chk("und_val", getlog(i), 32'(200 + i));
        chk("und_pulses", n_und, 1);
        chk("und_cnt", ucnt, 1);
        chk("und_busy", busy, 0);

        // Flush with three words still queued; a second request is ignored.
        do_reset(1);
        for (int k = 0; k < 7; k++) step(1'b1, 18'(100 + k), 1'b0);
        idle(2);
        step(1'b0, '0, 1'b1);
        lows = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.s_ready == 1'b0) lows++;
            step(1'b0, '0, i == 5);
        end
        chk("flush_lows", lows, 21);
        chk("flush_busy", busy, 0);
        for (int k = 0; k < 4; k++) step(1'b1, 18'(300 + k), 1'b0);
        idle(15);
        chk("flush_n", ylog.size(), 8);
        for (int i = 0; i < 4; i++) chk("flush_pre", getlog(i), 32'(100 + i));
        for (int i = 0; i < 4; i++) chk("flush_post", getlog(i + 4), 32'(300 + i));

        // Extreme values must pass bit-exact.
        do_reset(1);
        for (int k = 0; k < 8; k++) step(1'b1, pat[k%2], 1'b0);
        idle(20);
        chk("wc_n", ylog.size(), 8);
        for (int i = 0; i < 8; i++) chk("wc_val", getlog(i), pat[i%2]);

        // Reset in the middle of RUN.
        for (int k = 0; k < 7; k++) step(1'b1, 18'(50 + k), 1'b0);
        chk("mid_busy_pre", busy, 1);
        do_reset(3);
        chk("mid_x", x_in, 0);
        chk("mid_yout", y_out, 0);
        chk("mid_yv", y_valid, 0);
        chk("mid_und", underrun, 0);
        chk("mid_ucnt", ucnt, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ready", bus.s_ready, 1);
        idle(12);
        chk("mid_nolog", ylog.size(), 0);

        // Backpressure on the PRIME=9 instance, which never starts.
        bp_acc = 0;
        for (int k = 0; k < 10; k++) begin
            bp.s_valid = 1'b1;
            bp.s_data = 18'(400 + k);
            if (bp.s_ready == 1'b1) bp_acc++;
            idle(1);
        end
        bp.s_valid = 1'b0;
        chk("bp_acc", bp_acc, 8);
        chk("bp_ready", bp.s_ready, 0);
        chk("bp_busy", bp_busy, 0);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
